down_timer: RTL and testbench

Loadable N-bit down-counting timer with prescaler, one-shot and periodic modes, and a single-cycle terminal-count pulse. It is the decrementing counterpart of the team's loadable up-counter. It sits beside it in peripheral/control logic and generates timeouts, periodic ticks and delay windows for downstream FSMs.

---
 rtl/down_timer.sv | 75 +++++++
 tb/tb_down_timer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/down_timer.sv
// down_timer: loadable down-counting timer with prescaler, one-shot/periodic modes
// and a single-cycle terminal-count pulse.
module down_timer #(
    parameter int N = 4,
    parameter int P = 4
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         load_i,
    input  logic [N-1:0] load_val_i,
    input  logic         start_i,
    input  logic         stop_i,
    input  logic         periodic_i,
    input  logic [P-1:0] prescale_i,
    output logic [N-1:0] count_o,
    output logic         busy_o,
    output logic         tc_o
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t       state_q, state_d;
    logic [N-1:0] count_q, count_d;
    logic [N-1:0] reload_q, reload_d;
    logic [P-1:0] presc_q, presc_d;
    logic         tc_q, tc_d;
    logic [N-1:0] r;
    logic         tick;
    // A load in the same cycle as a start or reload is already the value to use.
    assign r    = load_i ? load_val_i : reload_q;
    assign tick = presc_q >= prescale_i;
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = r;
        presc_d  = presc_q;
        tc_d     = 1'b0;
        if (stop_i && state_q == RUN) begin
            state_d = IDLE;
            presc_d = '0;
        end else if (start_i) begin
            tc_d    = (r == '0);
            state_d = (r == '0) ? IDLE : RUN;
            count_d = r;
            presc_d = '0;
        end else if (state_q == IDLE) begin
            count_d = load_i ? load_val_i : count_q;
        end else begin
            presc_d = tick ? '0 : presc_q + P'(1);
            if (tick && count_q > N'(1)) begin
                count_d = count_q - N'(1);
            end else if (tick) begin
                tc_d    = 1'b1;
                count_d = (periodic_i) ? r : '0;
                state_d = (periodic_i && r != '0) ? RUN : IDLE;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            presc_q  <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            presc_q  <= presc_d;
            tc_q     <= tc_d;
        end
    end
    assign count_o = count_q;
    assign busy_o  = (state_q == RUN);
    assign tc_o    = tc_q;
endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: directed scoreboard bench for down_timer.
module tb_down_timer;
    logic       clk = 1'b0;
    logic       srst = 1'b1;
    logic       load_i = 1'b0;
    logic [3:0] load_val_i = '0;
    logic       start_i = 1'b0;
    logic       stop_i = 1'b0;
    logic       periodic_i = 1'b0;
    logic [3:0] prescale_i = '0;
    logic [3:0] count_o;
    logic       busy_o;
    logic       tc_o;

    typedef struct {
        string      tag;
        logic [3:0] c;
        logic       b;
        logic       t;
    } exp_t;
    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    down_timer #(.N(4), .P(4)) dut (
        .clk(clk), .srst(srst), .load_i(load_i), .load_val_i(load_val_i),
        .start_i(start_i), .stop_i(stop_i), .periodic_i(periodic_i),
        .prescale_i(prescale_i), .count_o(count_o), .busy_o(busy_o), .tc_o(tc_o)
    );

    always #5 clk = ~clk;

    task automatic expect_out(input string tag, input logic [3:0] c, input logic b, input logic t);
        exp_t e;
        e.tag = tag; e.c = c; e.b = b; e.t = t;
        exp_q.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        e = exp_q.pop_front();
        n_cmp++;
        assert (count_o === e.c) else begin
            n_err++;
            $error("FAIL %s count_o got %0d exp %0d", e.tag, count_o, e.c);
        end
        n_cmp++;
        assert (busy_o === e.b) else begin
            n_err++;
            $error("FAIL %s busy_o got %0b exp %0b", e.tag, busy_o, e.b);
        end
        n_cmp++;
        assert (tc_o === e.t) else begin
            n_err++;
            $error("FAIL %s tc_o got %0b exp %0b", e.tag, tc_o, e.t);
        end
    endtask

    task automatic step(input logic ld, input logic [3:0] lv, input logic st, input logic sp,
                        input logic [3:0] c, input logic b, input logic t, input string tag);
        load_i = ld; load_val_i = lv; start_i = st; stop_i = sp;
        expect_out(tag, c, b, t);
        @(posedge clk); #1;
        load_i = 1'b0; start_i = 1'b0; stop_i = 1'b0;
        check();
    endtask

    initial begin
        // reset with random activity on every input
        srst = 1'b1;
        expect_out("reset", 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            load_i = 1'($urandom); load_val_i = 4'($urandom); start_i = 1'($urandom);
            stop_i = 1'($urandom); periodic_i = 1'($urandom); prescale_i = 4'($urandom);
            @(posedge clk); #1;
        end
        check();
        srst = 1'b0; periodic_i = 1'b0; prescale_i = 4'd0;
        step(0, 0, 1, 0, 0, 0, 1, "rst_reload_zero");
        step(0, 0, 0, 0, 0, 0, 0, "tc_clear");
        // one-shot, D=0
        step(1, 3, 0, 0, 3, 0, 0, "os_load");
        step(0, 0, 1, 0, 3, 1, 0, "os_start");
        step(0, 0, 0, 0, 2, 1, 0, "os_2");
        step(0, 0, 0, 0, 1, 1, 0, "os_1");
        step(0, 0, 0, 0, 0, 0, 1, "os_tc");
        step(0, 0, 0, 0, 0, 0, 0, "os_idle");
        // periodic, D=1
        periodic_i = 1'b1; prescale_i = 4'd1;
        step(1, 2, 0, 0, 2, 0, 0, "per_load");
        step(0, 0, 1, 0, 2, 1, 0, "per_start");
        step(0, 0, 0, 0, 2, 1, 0, "per_2b");
        step(0, 0, 0, 0, 1, 1, 0, "per_1a");
        step(0, 0, 0, 0, 1, 1, 0, "per_1b");
        step(0, 0, 0, 0, 2, 1, 1, "per_tc1");
        step(0, 0, 0, 0, 2, 1, 0, "per_2b2");
        step(0, 0, 0, 0, 1, 1, 0, "per_1a2");
        step(0, 0, 0, 0, 1, 1, 0, "per_1b2");
        step(0, 0, 0, 0, 2, 1, 1, "per_tc2");
        step(0, 0, 0, 1, 2, 0, 0, "per_stop");
        step(0, 0, 0, 0, 2, 0, 0, "per_idle");
        // load during periodic run, D=0
        prescale_i = 4'd0;
        step(0, 0, 1, 0, 2, 1, 0, "ldr_start");
        step(1, 4, 0, 0, 1, 1, 0, "ldr_load_mid");
        step(0, 0, 0, 0, 4, 1, 1, "ldr_tc_new");
        step(0, 0, 0, 0, 3, 1, 0, "ldr_3");
        step(0, 0, 0, 0, 2, 1, 0, "ldr_2");
        step(0, 0, 0, 0, 1, 1, 0, "ldr_1");
        step(0, 0, 0, 0, 4, 1, 1, "ldr_tc2");
        step(0, 0, 0, 1, 4, 0, 0, "ldr_stop");
        // stop and retrigger, one-shot
        periodic_i = 1'b0;
        step(1, 5, 0, 0, 5, 0, 0, "sr_load");
        step(0, 0, 1, 0, 5, 1, 0, "sr_start");
        step(0, 0, 0, 0, 4, 1, 0, "sr_4");
        step(0, 0, 0, 0, 3, 1, 0, "sr_3");
        step(0, 0, 0, 1, 3, 0, 0, "sr_stop");
        step(0, 0, 0, 0, 3, 0, 0, "sr_hold");
        step(0, 0, 1, 0, 5, 1, 0, "sr_restart");
        step(0, 0, 0, 0, 4, 1, 0, "sr_r4");
        step(0, 0, 0, 0, 3, 1, 0, "sr_r3");
        step(0, 0, 0, 0, 2, 1, 0, "sr_r2");
        step(1, 7, 1, 0, 7, 1, 0, "sr_retrig7");
        step(0, 0, 0, 0, 6, 1, 0, "sr_6");
        step(0, 0, 0, 1, 6, 0, 0, "sr_stop2");
        // start coinciding with terminal tick
        step(1, 2, 0, 0, 2, 0, 0, "st_load");
        step(0, 0, 1, 0, 2, 1, 0, "st_start");
        step(0, 0, 0, 0, 1, 1, 0, "st_1");
        step(0, 0, 1, 0, 2, 1, 0, "st_on_tc");
        step(0, 0, 0, 0, 1, 1, 0, "st_1b");
        step(0, 0, 0, 0, 0, 0, 1, "st_tc");
        step(0, 0, 0, 0, 0, 0, 0, "st_idle");
        // stop coinciding with terminal tick
        step(0, 0, 1, 0, 2, 1, 0, "sp_start");
        step(0, 0, 0, 0, 1, 1, 0, "sp_1");
        step(0, 0, 0, 1, 1, 0, 0, "sp_on_tc");
        step(0, 0, 0, 0, 1, 0, 0, "sp_idle");
        // reset coinciding with terminal tick, then reload register must be cleared
        step(0, 0, 1, 0, 2, 1, 0, "rs_start");
        step(0, 0, 0, 0, 1, 1, 0, "rs_1");
        srst = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, "rs_on_tc");
        srst = 1'b0;
        step(0, 0, 1, 0, 0, 0, 1, "rs_reload_zero");
        step(0, 0, 0, 0, 0, 0, 0, "rs_idle");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
